// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared types for the program sequencer
// Contents: br_op_t branch-op encodings from the control decoder,
//           seq_state_t sequencer FSM states.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_BRC  = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4,
        BR_HALT = 3'd5
    } br_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address stack, depth S, D-bit entries
// Ports: clk, rst_n (async active-low), clear/push/pop controls,
//        push_data in, top/full/empty out.
// clear wins over push, push wins over pop; push when full and pop when
// empty are ignored (the caller turns them into faults).
module ret_stack #(
    parameter int S = 4,
    parameter int D = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(S + 1);
    localparam int AW = (S > 1) ? $clog2(S) : 1;

    logic [D-1:0]  mem_q [S];
    logic [CW-1:0] cnt_q;

    assign full  = (cnt_q == CW'(S));
    assign empty = (cnt_q == '0);
    assign top   = mem_q[AW'(cnt_q - 1'b1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entry storage needs no reset: only slots below cnt_q are ever read.
    always_ff @(posedge clk) begin
        if (!clear && push && !full) begin
            mem_q[cnt_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/prog_seq.sv
// rtl/prog_seq.sv - program sequencer: PC, branch target LUT, req/done handshake
// Optional feature macro: PROG_SEQ_RAS_EN (builds the return stack; without it
// CALL acts as JMP and RET faults).
// Ports: clk, reset (async active-low), req, stall, br_op, lut_idx, cnd,
//        lut_we/lut_waddr/lut_wdata (LUT write port),
//        prog_ctr, busy, done, fault (all registered).
module prog_seq
    import prog_seq_pkg::*;
#(
    parameter int D       = 12,
    parameter int L       = 4,
    parameter int S       = 4,
    parameter int DONE_PC = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic [2:0]   br_op,
    input  logic [L-1:0] lut_idx,
    input  logic         cnd,
    input  logic         lut_we,
    input  logic [L-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata,
    output logic [D-1:0] prog_ctr,
    output logic         busy,
    output logic         done,
    output logic         fault
);

    // A DONE_PC outside the PC range can never match, so the compare is
    // disabled outright rather than matching a truncated value.
    localparam bit           DONE_EN   = (DONE_PC < (2 ** D));
    localparam logic [D-1:0] DONE_PC_D = D'(DONE_PC);

    seq_state_t   state_q;
    logic [D-1:0] pc_q;
    logic         busy_q, done_q, fault_q;
    logic [D-1:0] lut_q [2 ** L];

    logic [D-1:0] pc_inc;
    logic [D-1:0] lut_rd;
    logic         is_done_pc;
    logic         advance;

    assign pc_inc     = pc_q + D'(1);
    assign lut_rd     = lut_q[lut_idx];
    assign is_done_pc = DONE_EN && (pc_q == DONE_PC_D);
    // A RUN edge that executes br_op rather than aborting, stalling or ending.
    assign advance    = (state_q == ST_RUN) && req && !stall &&
                        (br_op != BR_HALT) && !is_done_pc;

`ifdef PROG_SEQ_RAS_EN
    logic [D-1:0] stk_top;
    logic         stk_full, stk_empty;
    logic         stk_push, stk_pop, stk_clear;

    assign stk_push  = advance && (br_op == BR_CALL) && !stk_full;
    assign stk_pop   = advance && (br_op == BR_RET) && !stk_empty;
    // Stack is only meaningful inside one RUN; any exit empties it.
    assign stk_clear = (state_q != ST_RUN) || !req;

    ret_stack #(.S(S), .D(D)) u_ret_stack (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`endif

    // Writes land at the edge, so a same-cycle read sees the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2 ** L; i++) lut_q[i] <= '0;
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pc_q    <= '0;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    if (req) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                        pc_q    <= '0;
                        busy_q  <= 1'b0;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (!advance) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        case (br_op)
                            BR_JMP:  pc_q <= lut_rd;
                            BR_BRC:  pc_q <= cnd ? lut_rd : pc_inc;
`ifdef PROG_SEQ_RAS_EN
                            BR_CALL: begin
                                if (stk_full) begin
                                    state_q <= ST_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    fault_q <= 1'b1;
                                end else begin
                                    pc_q <= lut_rd;
                                end
                            end
                            BR_RET: begin
                                if (stk_empty) begin
                                    state_q <= ST_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    fault_q <= 1'b1;
                                end else begin
                                    pc_q <= stk_top;
                                end
                            end
`else
                            BR_CALL: pc_q <= lut_rd;
                            BR_RET: begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                fault_q <= 1'b1;
                            end
`endif
                            default: pc_q <= pc_inc;
                        endcase
                    end
                end
                ST_DONE: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                        pc_q    <= '0;
                        done_q  <= 1'b0;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pc_q    <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ctr = pc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_prog_seq.sv
// tb/tb_prog_seq.sv - directed self-checking bench for prog_seq
module tb_prog_seq;

    localparam int D = 12;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req = 1'b0;
    logic         stall = 1'b0;
    logic         cnd = 1'b0;
    logic         lut_we = 1'b0;
    logic [2:0]   br_op = 3'd0;
    logic [L-1:0] lut_idx = '0;
    logic [L-1:0] lut_waddr = '0;
    logic [D-1:0] lut_wdata = '0;
    logic [D-1:0] prog_ctr;
    logic         busy, done, fault;

    logic         req4 = 1'b0;
    logic [2:0]   br_op4 = 3'd0;
    logic [3:0]   pc4;
    logic         busy4, done4, fault4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_seq #(.D(D), .L(L), .S(4), .DONE_PC(128)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .stall     (stall),
        .br_op     (br_op),
        .lut_idx   (lut_idx),
        .cnd       (cnd),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .prog_ctr  (prog_ctr),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    prog_seq #(.D(4), .L(4), .S(4), .DONE_PC(32)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .req       (req4),
        .stall     (1'b0),
        .br_op     (br_op4),
        .lut_idx   (4'd0),
        .cnd       (1'b0),
        .lut_we    (1'b0),
        .lut_waddr (4'd0),
        .lut_wdata (4'd0),
        .prog_ctr  (pc4),
        .busy      (busy4),
        .done      (done4),
        .fault     (fault4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input int idx, input int val);
        lut_we    = 1'b1;
        lut_waddr = L'(idx);
        lut_wdata = D'(val);
        step();
        lut_we    = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (prog_ctr !== 12'd0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", prog_ctr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %0b expected 0", fault); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_run_to_done();
        req = 1'b1;
        step();
        n_cmp++; if (prog_ctr !== 12'd0 || busy !== 1'b1) begin n_err++; $display("FAIL start: pc=%0d busy=%0b expected pc=0 busy=1", prog_ctr, busy); end
        for (int i = 1; i <= 128; i++) begin
            step();
            n_cmp++; if (prog_ctr !== D'(i) || done !== 1'b0) begin n_err++; $display("FAIL seq_pc: pc=%0d done=%0b expected pc=%0d done=0", prog_ctr, done, i); end
        end
        step();
        n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL done_at_128: done=%0b fault=%0b busy=%0b expected 1/0/0", done, fault, busy); end
        n_cmp++; if (prog_ctr !== 12'd128) begin n_err++; $display("FAIL done_pc: got %0d expected 128", prog_ctr); end
        step();
        n_cmp++; if (done !== 1'b1 || prog_ctr !== 12'd128) begin n_err++; $display("FAIL done_hold: done=%0b pc=%0d expected 1/128", done, prog_ctr); end
        req = 1'b0;
        step();
        n_cmp++; if (done !== 1'b0 || prog_ctr !== 12'd0 || busy !== 1'b0) begin n_err++; $display("FAIL to_idle: done=%0b pc=%0d busy=%0b expected 0/0/0", done, prog_ctr, busy); end
    endtask

    task automatic test_branch();
        lut_write(3, 40);
        req = 1'b1;
        step();
        repeat (5) step();
        n_cmp++; if (prog_ctr !== 12'd5) begin n_err++; $display("FAIL pre_brc: got %0d expected 5", prog_ctr); end
        br_op = 3'd2; lut_idx = 4'd3; cnd = 1'b0;
        step();
        n_cmp++; if (prog_ctr !== 12'd6) begin n_err++; $display("FAIL brc_not_taken: got %0d expected 6", prog_ctr); end
        cnd = 1'b1;
        step();
        n_cmp++; if (prog_ctr !== 12'd40) begin n_err++; $display("FAIL brc_taken: got %0d expected 40", prog_ctr); end
        cnd = 1'b0; br_op = 3'd1;
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'd50;
        step();
        lut_we = 1'b0;
        n_cmp++; if (prog_ctr !== 12'd40) begin n_err++; $display("FAIL jmp_old_entry: got %0d expected 40", prog_ctr); end
        step();
        n_cmp++; if (prog_ctr !== 12'd50) begin n_err++; $display("FAIL jmp_new_entry: got %0d expected 50", prog_ctr); end
    endtask

    task automatic test_stall_halt();
        br_op = 3'd1; lut_idx = 4'd2; stall = 1'b1;
        lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 12'd90;
        step();
        lut_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            n_cmp++; if (prog_ctr !== 12'd50 || busy !== 1'b1) begin n_err++; $display("FAIL stall_hold: pc=%0d busy=%0b expected 50/1", prog_ctr, busy); end
        end
        stall = 1'b0;
        step();
        n_cmp++; if (prog_ctr !== 12'd90) begin n_err++; $display("FAIL stall_release: got %0d expected 90", prog_ctr); end
        br_op = 3'd5;
        step();
        n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || prog_ctr !== 12'd90) begin n_err++; $display("FAIL halt: done=%0b fault=%0b pc=%0d expected 1/0/90", done, fault, prog_ctr); end
        br_op = 3'd0; req = 1'b0;
        step();
    endtask

    task automatic test_abort();
        req = 1'b1;
        step();
        repeat (3) step();
        n_cmp++; if (prog_ctr !== 12'd3) begin n_err++; $display("FAIL abort_pre: got %0d expected 3", prog_ctr); end
        req = 1'b0;
        step();
        n_cmp++; if (prog_ctr !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort: pc=%0d busy=%0b done=%0b expected 0/0/0", prog_ctr, busy, done); end
    endtask

    task automatic test_stack();
        lut_write(4, 60);
        req = 1'b1;
        step();
        repeat (10) step();
        br_op = 3'd3; lut_idx = 4'd4;
        step();
        n_cmp++; if (prog_ctr !== 12'd60) begin n_err++; $display("FAIL call: got %0d expected 60", prog_ctr); end
        br_op = 3'd4;
        step();
`ifdef PROG_SEQ_RAS_EN
        n_cmp++; if (prog_ctr !== 12'd11 || done !== 1'b0) begin n_err++; $display("FAIL ret: pc=%0d done=%0b expected 11/0", prog_ctr, done); end
        br_op = 3'd3;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++; if (prog_ctr !== 12'd60 || done !== 1'b0) begin n_err++; $display("FAIL nested_call: pc=%0d done=%0b expected 60/0", prog_ctr, done); end
        end
        step();
        n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || prog_ctr !== 12'd60) begin n_err++; $display("FAIL overflow: done=%0b fault=%0b pc=%0d expected 1/1/60", done, fault, prog_ctr); end
`else
        n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || prog_ctr !== 12'd60) begin n_err++; $display("FAIL ret_no_ras: done=%0b fault=%0b pc=%0d expected 1/1/60", done, fault, prog_ctr); end
`endif
        br_op = 3'd0; req = 1'b0;
        step();
        n_cmp++; if (fault !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL fault_clear: fault=%0b done=%0b expected 0/0", fault, done); end
        req = 1'b1;
        step();
        br_op = 3'd4;
        step();
        n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || prog_ctr !== 12'd0) begin n_err++; $display("FAIL ret_empty: done=%0b fault=%0b pc=%0d expected 1/1/0", done, fault, prog_ctr); end
        br_op = 3'd0; req = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        lut_write(1, 70);
        req = 1'b1;
        step();
        br_op = 3'd1; lut_idx = 4'd1;
        step();
        br_op = 3'd0;
        n_cmp++; if (prog_ctr !== 12'd70) begin n_err++; $display("FAIL pre_reset: got %0d expected 70", prog_ctr); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (prog_ctr !== 12'd0 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset: pc=%0d busy=%0b expected 0/0", prog_ctr, busy); end
        req = 1'b0;
        step();
        reset = 1'b1;
        step();
        req = 1'b1;
        step();
        br_op = 3'd1; lut_idx = 4'd1;
        step();
        n_cmp++; if (prog_ctr !== 12'd0) begin n_err++; $display("FAIL lut_cleared: got %0d expected 0", prog_ctr); end
        br_op = 3'd0; req = 1'b0;
        step();
    endtask

    task automatic test_narrow();
        req4 = 1'b1;
        step();
        repeat (15) step();
        n_cmp++; if (pc4 !== 4'd15) begin n_err++; $display("FAIL narrow_top: got %0d expected 15", pc4); end
        step();
        n_cmp++; if (pc4 !== 4'd0 || done4 !== 1'b0 || busy4 !== 1'b1) begin n_err++; $display("FAIL narrow_wrap: pc=%0d done=%0b busy=%0b expected 0/0/1", pc4, done4, busy4); end
        repeat (7) step();
        br_op4 = 3'd5;
        step();
        n_cmp++; if (done4 !== 1'b1 || fault4 !== 1'b0 || pc4 !== 4'd7) begin n_err++; $display("FAIL narrow_halt: done=%0b fault=%0b pc=%0d expected 1/0/7", done4, fault4, pc4); end
        br_op4 = 3'd0; req4 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_run_to_done();
        test_branch();
        test_stall_halt();
        test_abort();
        test_stack();
        test_async_reset();
        test_narrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_seq.md
# prog_seq

Parametrised program sequencer for the 9-bit-instruction core: owns the program counter, a run-time-writable branch target LUT, an optional return-address stack, and the req/done start/finish handshake. It replaces the fixed-width PC plus hard-wired PC LUT and the `done = (prog_ctr == 128)` compare with one registered block. The instruction ROM is addressed by `prog_ctr`; the control decoder drives `br_op`/`lut_idx`; the ALU's registered condition flag drives `cnd`.

## Interface
- D, 12: program counter width
- L, 4: LUT index width (2^L target entries)
- S, 4: return stack depth (entries), S >= 1
- DONE_PC, 128: PC value that ends a program
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- req  in  1  run request; level, held high for the whole program
- stall  in  1  hold PC this cycle
- br_op  in  3  branch op: NONE=0, JMP=1, BRC=2 (taken if cnd), CALL=3, RET=4, HALT=5; 6-7 treated as NONE
- lut_idx  in  L  LUT entry selected for JMP/BRC/CALL
- cnd  in  1  registered condition flag
- lut_we  in  1  LUT write enable
- lut_waddr  in  L  LUT write index
- lut_wdata  in  D  LUT write data (absolute target)
- prog_ctr  out  D  current PC
- busy  out  1  high in RUN
- done  out  1  high in DONE
- fault  out  1  stack overflow/underflow or unsupported op; valid while done

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, prog_ctr=0, busy=0, done=0, fault=0, stack empty, all LUT entries 0.
- IDLE: prog_ctr held at 0. req=1 -> RUN next edge; first fetch address is 0.
- RUN, per edge, priority order: req=0 -> IDLE (abort, PC=0, stack cleared); stall=1 -> hold everything; HALT or prog_ctr==DONE_PC -> DONE; otherwise next PC:
  - NONE, BRC not taken: prog_ctr+1, mod 2^D (wraps 2^D-1 -> 0)
  - JMP, BRC taken: lut[lut_idx]
  - CALL: push prog_ctr+1, go to lut[lut_idx]; push when full -> DONE with fault=1
  - RET: pop into PC; pop when empty -> DONE with fault=1
- DONE: PC frozen, done=1, fault sticky; leave to IDLE only when req=0. req staying high keeps DONE (no auto-restart).
- LUT writes accepted in any state. Write and read of the same index in one cycle: branch uses the old entry; new value visible next cycle.
- DONE_PC >= 2^D: compare never matches; program ends only by HALT.

## Timing
- Next-PC is combinational from br_op/lut_idx/cnd/stack top; prog_ctr is registered: a branch in cycle n fetches its target in cycle n+1 (no delay slot).
- done/busy/fault registered, asserted the edge after the terminating condition.
- IDLE->RUN on req takes one edge; DONE->IDLE on req low takes one edge.
- Asynchronous reset mid-run: all outputs to reset values immediately, LUT contents cleared.

## Configuration
- PROG_SEQ_RAS_EN defined: return stack of depth S built; CALL/RET as above.
- Undefined: no stack storage; CALL behaves as JMP (no push); RET sets fault=1 and ends in DONE.

## Structure
- prog_seq_pkg: br_op_t enum (encodings above), seq_state_t enum (IDLE/RUN/DONE).
- Sub-module ret_stack (parameters S, D): push/pop/clear, top, full, empty; instantiated only under PROG_SEQ_RAS_EN.
- LUT is flop storage inside prog_seq.

## Test plan
- Reset, req=1, all NONE -> prog_ctr 0,1,...,128; done=1 the edge after PC reaches 128, fault=0; hold req high -> done remains 1; req=0 -> IDLE, PC=0.
- Write lut[3]=40; at PC 5 BRC idx3 with cnd=0 -> 6; at PC 6 BRC idx3 with cnd=1 -> 40; lut_we to idx3 (=50) same cycle as JMP idx3 -> 40, next JMP idx3 -> 50.
- RAS_EN, S=4: CALL at PC 10 to lut=60 -> 60; RET -> 11; five nested CALLs -> DONE, fault=1.
- RET with empty stack -> DONE, fault=1; without RAS_EN, CALL at 10 to 60 -> 60 with no push, then RET -> fault=1.
- stall held 3 cycles with br_op=JMP -> PC unchanged, jump taken on first unstalled edge; req dropped mid-run -> IDLE, PC=0; reset asserted at PC 70 -> PC=0 immediately.
- D=4, DONE_PC=32 -> PC wraps 15 -> 0; HALT at PC 7 -> done=1, fault=0.
